// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU sequencer: opcodes, ALU codes,
// instruction field positions and FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] PC_INC = 32'd1;

    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_DIV = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1011;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_MCLR  = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b110;
    localparam logic [2:0] OP_STORE = 3'b111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int FA_HI  = 28;
    localparam int FA_LO  = 27;
    localparam int DST_HI = 26;
    localparam int DST_LO = 25;
    localparam int IMM_HI = 24;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ARITH, CL_MCLR, CL_HALT, CL_LOAD, CL_STORE
    } iclass_t;

    function automatic logic [31:0] zext_imm(input logic [31:0] ir);
        return {7'b0, ir[IMM_HI:IMM_LO]};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and the
// flags the sequencer uses to choose between the MEM and WB paths.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [2:0] i_opcode,
    output logic [2:0] o_class,
    output logic [3:0] o_alu_op,
    output logic       o_uses_mem,
    output logic       o_writes_reg
);

    always_comb begin
        o_class      = CL_ARITH;
        o_alu_op     = 4'b0000;
        o_uses_mem   = 1'b0;
        o_writes_reg = 1'b0;
        case (i_opcode)
            OP_ADD:   begin o_alu_op = ALU_ADD; o_writes_reg = 1'b1; end
            OP_SUB:   begin o_alu_op = ALU_SUB; o_writes_reg = 1'b1; end
            OP_DIV:   begin o_alu_op = ALU_DIV; o_writes_reg = 1'b1; end
            OP_MUL:   begin o_alu_op = ALU_MUL; o_writes_reg = 1'b1; end
            OP_MCLR:  begin o_class = CL_MCLR; o_uses_mem = 1'b1; end
            OP_HALT:  o_class = CL_HALT;
            // Memory ops use the ALU adder to form R[FonteA] + Imm.
            OP_LOAD:  begin
                o_class = CL_LOAD; o_alu_op = ALU_ADD;
                o_uses_mem = 1'b1; o_writes_reg = 1'b1;
            end
            OP_STORE: begin
                o_class = CL_STORE; o_alu_op = ALU_ADD; o_uses_mem = 1'b1;
            end
            default:  o_class = CL_ARITH;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM: fetch, decode, execute, memory and write-back,
// owning every strobe sent to the memory, register bank and ALU.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] data_read,
    input  logic [31:0] data_src_1,
    input  logic [31:0] data_src_2,
    input  logic [31:0] alu_rd,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        op2_en,
    output logic        op2_rw,
    output logic        m_clear,
    output logic [1:0]  src_1,
    output logic [1:0]  src_2,
    output logic        opwrite,
    output logic [1:0]  reg_write,
    output logic [31:0] reg_data,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_y, r_d;
    logic [2:0]  w_class;
    logic [3:0]  w_alu_op;
    logic        w_uses_mem, w_writes_reg;

    instr_decode u_decode (
        .i_opcode     (r_ir[OPC_HI:OPC_LO]),
        .o_class      (w_class),
        .o_alu_op     (w_alu_op),
        .o_uses_mem   (w_uses_mem),
        .o_writes_reg (w_writes_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= 32'd0;
            r_ir    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_y     <= 32'd0;
            r_d     <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE:   if (start) r_pc <= 32'd0;
                ST_FETCH:  r_ir <= instruction;
                ST_DECODE: begin
                    r_a <= data_src_1;
                    r_b <= data_src_2;
                end
                ST_EXEC:   r_y <= alu_rd;
                ST_MEM: begin
                    if (w_class == CL_LOAD) r_d <= data_read;
                    // LOAD advances pc in WB; STORE/MCLR finish here.
                    if (!w_writes_reg) r_pc <= r_pc + PC_INC;
                end
                ST_WB:     r_pc <= r_pc + PC_INC;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        op2_en    = 1'b0;
        op2_rw    = 1'b0;
        m_clear   = 1'b0;
        src_1     = 2'd0;
        src_2     = 2'd0;
        opwrite   = 1'b0;
        reg_write = 2'd0;
        reg_data  = 32'd0;
        alu_rs    = 32'd0;
        alu_rt    = 32'd0;
        alu_op    = 4'd0;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                src_1  = r_ir[FA_HI:FA_LO];
                src_2  = r_ir[DST_HI:DST_LO];
                w_next = (w_class == CL_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_rs = r_a;
                alu_rt = zext_imm(r_ir);
                alu_op = w_alu_op;
                w_next = w_uses_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                w_next = ST_FETCH;
                case (w_class)
                    CL_LOAD: begin
                        op2_en   = 1'b1;
                        mem_addr = r_y;
                        w_next   = ST_WB;
                    end
                    CL_STORE: begin
                        op2_en    = 1'b1;
                        op2_rw    = 1'b1;
                        mem_addr  = r_y;
                        mem_wdata = r_b;
                    end
                    CL_MCLR: m_clear = 1'b1;
                    default: ;
                endcase
            end
            ST_WB: begin
                opwrite   = 1'b1;
                reg_write = r_ir[DST_HI:DST_LO];
                reg_data  = (w_class == CL_LOAD) ? r_d : r_y;
                w_next    = ST_FETCH;
            end
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign pc        = r_pc;
    assign halted    = (r_state == ST_HALT);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign dbg_state = r_state;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control FSM that sequences the instruction memory/data memory, 4-entry register bank and ALU into a working processor. It fetches 32-bit instructions, decodes them, drives register reads, ALU operation, memory access and register write-back in fixed per-class cycle counts, and stops on HALT. It sits between the shared memory, register bank and ALU instances and owns every control strobe they receive.

## Interface
- PC_INC, 1: PC increment per instruction (word addressing).
- ALU_ADD / ALU_SUB / ALU_DIV / ALU_MUL, 4'b1000 / 4'b1001 / 4'b1010 / 4'b1011: ALU op codes driven per opcode.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  leave IDLE and begin fetching at PC 0.
- instruction  in  32  memory instruction port (combinational on pc).
- data_read  in  32  memory data read port.
- data_src_1, data_src_2  in  32  register bank read data.
- alu_rd  in  32  ALU result.
- pc  out  32  memory instruction address.
- mem_addr, mem_wdata  out  32  data-port address / write data.
- op2_en, op2_rw  out  1  data-port enable; rw=1 write, 0 read.
- m_clear  out  1  memory clear strobe.
- src_1, src_2  out  2  register read selects.
- opwrite  out  1  register write enable.
- reg_write  out  2  register write select.
- reg_data  out  32  register write data.
- alu_rs, alu_rt  out  32  ALU operands; alu_op  out  4.
- halted  out  1  high in HALT.
- busy  out  1  high in any state except IDLE and HALT.

## Operation
- Instruction: opcode[31:29], FonteA[28:27], Dest[26:25], Imm[24:0]; Imm zero-extended to 32.
- Opcodes: 000 ADD, 001 SUB, 010 DIV, 011 MUL: R[Dest] = R[FonteA] op zext(Imm). 100 MCLR: pulse m_clear. 101 HALT. 110 LOAD: R[Dest] = mem[R[FonteA]+zext(Imm)]. 111 STORE: mem[R[FonteA]+zext(Imm)] = R[Dest].
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: wait for start=1, then go to FETCH with pc=0.
- FETCH: latch instruction into IR.
- DECODE: src_1=FonteA, src_2=Dest; latch A=data_src_1, B=data_src_2. HALT goes to HALT; all other opcodes go to EXEC.
- EXEC: alu_rs=A, alu_rt=zext(Imm). alu_op is the opcode's op for arithmetic and ALU_ADD for LOAD/STORE (address). Latch Y=alu_rd. Arithmetic goes to WB; 100/110/111 go to MEM.
- MEM: LOAD: op2_en=1, op2_rw=0, mem_addr=Y; latch D=data_read; then WB. STORE: op2_en=1, op2_rw=1, mem_addr=Y, mem_wdata=B. MCLR: m_clear=1. STORE and MCLR then advance pc and go to FETCH.
- WB: opwrite=1, reg_write=Dest, reg_data = Y for arithmetic, D for LOAD; advance pc, then FETCH.
- HALT: sticky until rst. start is ignored. pc is frozen at the HALT instruction address.
- Strobes op2_en, m_clear and opwrite are high for exactly one cycle and low in every other state.
- Arithmetic wraps mod 2^32; pc wraps mod 2^32. The ALU defines division by zero; the sequencer does not check it.

## Timing
- Reset (async): state=IDLE, pc=0, IR/A/B/Y/D=0. All strobes 0, halted=0, busy=0. All other outputs are 0.
- Cycles per instruction: arithmetic 4 (F,D,E,WB), LOAD 5, STORE 4, MCLR 4. HALT reaches state HALT 2 cycles after entering FETCH.
- pc updates on the edge leaving WB or MEM, so the next FETCH sees the new pc.
- A register written in WB is readable by the next instruction's DECODE: the bank writes on the edge, and DECODE is at least 2 cycles later.
- rst asserted mid-instruction aborts it immediately. Strobes drop asynchronously, so no partial write is issued after reset assertion.
- start held high during execution has no effect.

## Structure
- Package cpu_pkg holds: opcode localparams, state encoding enum, ALU op constants, and the instruction field slice positions.
- One sub-module, instr_decode: combinational IR -> {class, alu_op, uses_mem, writes_reg}. Everything else is in the FSM.

## Test plan
- Reset then start, instr0 = ADD FonteA=R0(0) Dest=R1 Imm=5 -> opwrite pulse 4 cycles after FETCH, reg_write=1, reg_data=5, pc=1.
- Preloaded R1=7, SUB R1->R2 Imm=3 -> alu_op=4'b1001 in EXEC, R2=4 written in WB.
- STORE Dest=R2(4), FonteA=R0, Imm=16, then LOAD FonteA=R0 Imm=16 Dest=R3 -> op2_en/op2_rw=1 with addr 16 and wdata 4, then a read at addr 16, and R3=4 on the 5th cycle.
- MCLR -> m_clear high exactly 1 cycle, no opwrite, pc advances by 1.
- HALT at pc=3 -> halted=1, busy=0, pc stays 3, and no strobes for 20 cycles despite start pulses.
- rst asserted during MEM of a STORE -> op2_en drops immediately, state IDLE, pc=0, and a re-run produces a correct sequence.
